// File: rtl/bht_pkg.sv
// Shared widths, write_data field positions and the entry record for the branch history table.
package bht_pkg;

    localparam int PC_W    = 16;
    localparam int OFF_W   = 16;
    localparam int WDATA_W = 33;

    localparam int WD_PC_HI  = 32;
    localparam int WD_PC_LO  = 17;
    localparam int WD_OFF_HI = 16;
    localparam int WD_OFF_LO = 1;
    localparam int WD_HIST   = 0;

    typedef struct packed {
        logic             valid;
        logic [PC_W-1:0]  pc;
        logic [OFF_W-1:0] offset;
        logic             history;
    } bht_entry_t;

endpackage

// File: rtl/branch_history_table_if.sv
// Update stream from the branch controller plus the fetch-side lookup for the branch history table.
interface branch_history_table_if
    import bht_pkg::*;
#(
    parameter int PTR_W = 3
) ();

    logic               write_en;
    logic [WDATA_W-1:0] write_data;
    logic               flush;
    logic [PC_W-1:0]    pc_fetch;
    logic               hit;
    logic               history;
    logic [PC_W-1:0]    target;
    logic [PTR_W:0]     count;

    modport master (
        output write_en, write_data, flush, pc_fetch,
        input  hit, history, target, count
    );

    modport slave (
        input  write_en, write_data, flush, pc_fetch,
        output hit, history, target, count
    );

endinterface

// File: rtl/bht_match.sv
// Fully-associative PC compare: one-hot match over all valid entries plus an any-hit bit.
module bht_match
    import bht_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic [PC_W-1:0]               pc_i,
    input  logic [ENTRIES-1:0]            valid_i,
    input  logic [ENTRIES-1:0][PC_W-1:0]  pcs_i,
    output logic [ENTRIES-1:0]            match_o,
    output logic                          any_o
);

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
        assign match_o[gi] = valid_i[gi] && (pcs_i[gi] == pc_i);
    end

    assign any_o = |match_o;

endmodule

// File: rtl/branch_history_table.sv
// Branch history table: combinational lookup on the fetch PC, round-robin fill, in-place update.
// Define BHT_BYPASS_EN to forward a same-cycle update for the fetched PC straight to the outputs.
module branch_history_table
    import bht_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int PTR_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_history_table_if.slave  bus
);

    localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(ENTRIES);

    bht_entry_t [ENTRIES-1:0] entries_q, entries_d;
    logic [PTR_W-1:0]         rpl_ptr_q, rpl_ptr_d;
    logic [PTR_W:0]           count_q, count_d;

    logic [PC_W-1:0]  wr_pc;
    logic [OFF_W-1:0] wr_off;
    logic             wr_hist;

    assign wr_pc   = bus.write_data[WD_PC_HI:WD_PC_LO];
    assign wr_off  = bus.write_data[WD_OFF_HI:WD_OFF_LO];
    assign wr_hist = bus.write_data[WD_HIST];

    logic [ENTRIES-1:0]           valid_vec;
    logic [ENTRIES-1:0][PC_W-1:0] pc_vec;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_flat
        assign valid_vec[gi] = entries_q[gi].valid;
        assign pc_vec[gi]    = entries_q[gi].pc;
    end

    logic [ENTRIES-1:0] lk_oh, wr_oh;
    logic               lk_any, wr_any;

    bht_match #(.ENTRIES(ENTRIES)) u_match_lk (
        .pc_i    (bus.pc_fetch),
        .valid_i (valid_vec),
        .pcs_i   (pc_vec),
        .match_o (lk_oh),
        .any_o   (lk_any)
    );

    bht_match #(.ENTRIES(ENTRIES)) u_match_wr (
        .pc_i    (wr_pc),
        .valid_i (valid_vec),
        .pcs_i   (pc_vec),
        .match_o (wr_oh),
        .any_o   (wr_any)
    );

    // Matches are one-hot, so an AND-OR mux is enough; invalid entries never reach the outputs.
    logic            lk_hit;
    logic            lk_hist;
    logic [PC_W-1:0] lk_tgt;

    always_comb begin
        lk_hit  = lk_any;
        lk_hist = 1'b0;
        lk_tgt  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (lk_oh[i]) begin
                lk_hist = lk_hist | entries_q[i].history;
                lk_tgt  = lk_tgt | (entries_q[i].pc + entries_q[i].offset);
            end
        end
`ifdef BHT_BYPASS_EN
        if (bus.write_en && (wr_pc == bus.pc_fetch)) begin
            lk_hit  = 1'b1;
            lk_hist = wr_hist;
            lk_tgt  = wr_pc + wr_off;
        end
`endif
    end

    assign bus.hit     = lk_hit;
    assign bus.history = lk_hist;
    assign bus.target  = lk_tgt;
    assign bus.count   = count_q;

    always_comb begin
        entries_d = entries_q;
        rpl_ptr_d = rpl_ptr_q;
        count_d   = count_q;
        if (bus.flush) begin
            for (int i = 0; i < ENTRIES; i++) entries_d[i].valid = 1'b0;
            rpl_ptr_d = '0;
            count_d   = '0;
        end else if (bus.write_en) begin
            if (wr_any) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (wr_oh[i]) begin
                        entries_d[i].offset  = wr_off;
                        entries_d[i].history = wr_hist;
                    end
                end
            end else begin
                // Pointer wraps naturally since ENTRIES == 2**PTR_W.
                entries_d[rpl_ptr_q] = '{valid: 1'b1, pc: wr_pc, offset: wr_off, history: wr_hist};
                rpl_ptr_d = rpl_ptr_q + 1'b1;
                if (count_q != CNT_MAX) count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q <= '0;
            rpl_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            rpl_ptr_q <= rpl_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Directed plus random stimulus against a FIFO-of-records reference model of the table.
module tb_branch_history_table;

    logic clk;
    logic rst;

    branch_history_table_if #(.PTR_W(3)) bus ();

    branch_history_table #(.ENTRIES(8), .PTR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: records in insertion order; the oldest is evicted when eight are held.
    typedef struct {
        logic [15:0] pc;
        logic [15:0] off;
        logic        h;
    } rec_t;
    rec_t q[$];

    function automatic int find(input logic [15:0] pc);
        for (int i = 0; i < q.size(); i++) if (q[i].pc == pc) return i;
        return -1;
    endfunction

    task automatic step(input logic r, input logic fl, input logic we,
                        input logic [32:0] wd, input logic [15:0] pcf);
        int idx;
        logic        eh, ehist;
        logic [15:0] etgt;
        rec_t        rc;
        rst           = r;
        bus.flush     = fl;
        bus.write_en  = we;
        bus.write_data = wd;
        bus.pc_fetch  = pcf;
        #3;
        idx = find(pcf);
        eh    = (idx >= 0);
        ehist = eh ? q[idx].h : 1'b0;
        etgt  = eh ? q[idx].pc + q[idx].off : 16'h0;
`ifdef BHT_BYPASS_EN
        if (we && wd[32:17] == pcf) begin
            eh = 1'b1; ehist = wd[0]; etgt = wd[32:17] + wd[16:1];
        end
`endif
        chk("hit",     32'(bus.hit),     32'(eh));
        chk("history", 32'(bus.history), 32'(ehist));
        chk("target",  32'(bus.target),  32'(etgt));
        chk("count",   32'(bus.count),   32'(q.size()));
        @(posedge clk);
        if (r || fl) begin
            q.delete();
        end else if (we) begin
            idx = find(wd[32:17]);
            if (idx >= 0) begin
                q[idx].off = wd[16:1];
                q[idx].h   = wd[0];
            end else begin
                if (q.size() == 8) void'(q.pop_front());
                rc.pc = wd[32:17]; rc.off = wd[16:1]; rc.h = wd[0];
                q.push_back(rc);
            end
        end
        #1;
    endtask

    task automatic wr(input logic [15:0] pc, input logic [15:0] off, input logic h);
        step(1'b0, 1'b0, 1'b1, {pc, off, h}, 16'h0);
    endtask

    // Idle cycle with explicit expected values in addition to the model checks.
    task automatic look(input logic [15:0] pcf, input logic eh, input logic ehist,
                        input logic [15:0] etgt, input int ecnt);
        rst = 1'b0; bus.flush = 1'b0; bus.write_en = 1'b0; bus.pc_fetch = pcf;
        bus.write_data = 33'($urandom);
        #3;
        chk("k_hit",     32'(bus.hit),     32'(eh));
        chk("k_history", 32'(bus.history), 32'(ehist));
        chk("k_target",  32'(bus.target),  32'(etgt));
        chk("k_count",   32'(bus.count),   32'(ecnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; bus.flush = 1'b0; bus.write_en = 1'b0;
        bus.write_data = '0; bus.pc_fetch = '0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();

        look(16'h0010, 1'b0, 1'b0, 16'h0000, 0);
        wr(16'h0010, 16'h0004, 1'b1);
        look(16'h0010, 1'b1, 1'b1, 16'h0014, 1);
        wr(16'h0010, 16'hFFFC, 1'b1);
        look(16'h0010, 1'b1, 1'b1, 16'h000C, 1);
        wr(16'h0010, 16'hFFF0, 1'b0);
        look(16'h0010, 1'b1, 1'b0, 16'h0000, 1);

        // Fill; pointer sits at 1 after the first record, so 0x0100..0x0106 fill it, 0x0107 evicts 0x0010.
        for (int i = 0; i < 8; i++) wr(16'h0100 + 16'(i), 16'(i), 1'b1);
        look(16'h0010, 1'b0, 1'b0, 16'h0000, 8);
        wr(16'h0200, 16'h0010, 1'b1);
        look(16'h0100, 1'b0, 1'b0, 16'h0000, 8);
        look(16'h0200, 1'b1, 1'b1, 16'h0210, 8);
        wr(16'h0300, 16'h0001, 1'b0);
        look(16'h0101, 1'b0, 1'b0, 16'h0000, 8);
        look(16'h0102, 1'b1, 1'b1, 16'h0104, 8);

        // Same-cycle write and lookup.
        step(1'b0, 1'b0, 1'b1, {16'h0030, 16'h0002, 1'b1}, 16'h0030);
        look(16'h0030, 1'b1, 1'b1, 16'h0032, 8);

        // Flush drops a concurrent write.
        step(1'b0, 1'b1, 1'b1, {16'h0400, 16'h0002, 1'b1}, 16'h0030);
        look(16'h0400, 1'b0, 1'b0, 16'h0000, 0);
        look(16'h0030, 1'b0, 1'b0, 16'h0000, 0);
        wr(16'h0500, 16'h0008, 1'b1);
        look(16'h0500, 1'b1, 1'b1, 16'h0508, 1);

        // Reset mid-fill.
        wr(16'h0501, 16'h0001, 1'b0);
        step(1'b1, 1'b0, 1'b1, {16'h0502, 16'h0001, 1'b1}, 16'h0500);
        look(16'h0500, 1'b0, 1'b0, 16'h0000, 0);
        look(16'h0502, 1'b0, 1'b0, 16'h0000, 0);

        for (int n = 0; n < 600; n++) begin
            logic        r, fl, we;
            logic [15:0] wpc, pcf;
            r   = ($urandom_range(0, 79) == 0);
            fl  = ($urandom_range(0, 39) == 0);
            we  = ($urandom_range(0, 3) != 0);
            wpc = 16'h0100 + 16'($urandom_range(0, 11));
            pcf = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0100 + 16'($urandom_range(0, 11));
            step(r, fl, we, {wpc, 16'($urandom), 1'($urandom)}, pcf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
